// File: rtl/stream_demux8.sv
// 1-to-8 valid/ready stream demultiplexer with one holding register per output channel.
// Optional packet lock (route a whole packet by its first beat's in_sel) under `DEMUX_LOCK_EN.
module stream_demux8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic [2:0]     in_sel,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [8*W-1:0] out_data,
    output logic [7:0]     out_valid,
    input  logic [7:0]     out_ready,
    output logic           busy
);

    logic [7:0]   valid_q, valid_d;
    logic [W-1:0] data_q [8];
    logic [W-1:0] data_d [8];
    logic [2:0]   dest;
    logic         accept;

`ifdef DEMUX_LOCK_EN
    // state  | meaning
    // IDLE   | between packets, beat routed by its own in_sel
    // LOCKED | mid-packet, beats routed to lock_sel_q until in_last
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [2:0] lock_sel_q, lock_sel_d;

    assign dest = (state_q == LOCKED) ? lock_sel_q : in_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!in_last) begin
                        state_d    = LOCKED;
                        lock_sel_d = in_sel;
                    end
                end
                LOCKED: begin
                    if (in_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
`else
    logic unused_last;
    assign unused_last = in_last;
    assign dest        = in_sel;
`endif

    // A channel accepts when empty or when its current beat drains this cycle.
    assign in_ready = ~valid_q[dest] | out_ready[dest];
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q & ~out_ready;
        for (int k = 0; k < 8; k++) data_d[k] = data_q[k];
        if (accept) begin
            valid_d[dest] = 1'b1;
            data_d[dest]  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < 8; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 8; k++) data_q[k] <= data_d[k];
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_out
        assign out_data[k*W +: W] = data_q[k];
    end

    assign out_valid = valid_q;
    assign busy      = |valid_q;

endmodule
